// File: rtl/expr_scanner_if.sv
// Character stream and verdict bundle for expr_scanner: the source drives in/in_valid,
// the scanner returns the registered verdict outputs plus its FSM state for observation.
interface expr_scanner_if #(
  parameter int CNT_W = 8
);
  logic [7:0]       in;
  logic             in_valid;
  logic             out;
  logic             err;
  logic             done;
  logic             accept;
  logic [CNT_W-1:0] operands;
  logic [2:0]       dbg_state;

  // in is consumed on every rising edge where in_valid=1; there is no backpressure.
  modport master (
    output in, in_valid,
    input  out, err, done, accept, operands, dbg_state
  );

  modport slave (
    input  in, in_valid,
    output out, err, done, accept, operands, dbg_state
  );
endinterface

// File: rtl/expr_scanner.sv
// Streaming recognizer for infix expressions: multi-digit operands, + - * /, NUL-terminated.
// Define PAREN_EN to recognise '(' / ')' with nesting up to MAX_DEPTH.
module expr_scanner #(
  parameter int MAX_DIGITS = 4,
  parameter int MAX_DEPTH  = 3,
  parameter int CNT_W      = 8
) (
  input logic          clk,
  input logic          clr,
  expr_scanner_if.slave bus
);

  localparam int DGW = $clog2(MAX_DIGITS + 1);
  localparam logic [CNT_W-1:0] OPS_MAX = '1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_NUM  = 3'd1,
    S_OPR  = 3'd2,
    S_CLS  = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    D_HOLD,
    D_INC,
    D_DEC,
    D_CLR
  } depth_op_t;

  state_t           state_q, state_d;
  logic [DGW-1:0]   digits_q, digits_d;
  logic [CNT_W-1:0] operands_q, ops_d, ops_base, ops_inc;
  logic             err_q, err_d, err_base;
  logic             done_q, done_d;
  logic             accept_q, accept_d;
  logic             out_q;
  depth_op_t        depth_op;
  logic             depth_zero, depth_full, depth_d_zero;
  logic             is_dig, is_op, is_lp, is_rp, is_term;

  always_comb begin
    is_dig  = (bus.in >= 8'h30) && (bus.in <= 8'h39);
    is_op   = (bus.in == 8'h2B) || (bus.in == 8'h2D) || (bus.in == 8'h2A) || (bus.in == 8'h2F);
    is_term = (bus.in == 8'h00);
`ifdef PAREN_EN
    is_lp   = (bus.in == 8'h28);
    is_rp   = (bus.in == 8'h29);
`else
    is_lp   = 1'b0;
    is_rp   = 1'b0;
`endif
  end

  // The finished string's err/operands stay visible during the done cycle and
  // are discarded on the following edge, so the next string starts from zero.
  always_comb begin
    ops_base = done_q ? '0 : operands_q;
    err_base = done_q ? 1'b0 : err_q;
    ops_inc  = (ops_base == OPS_MAX) ? ops_base : ops_base + 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    ops_d    = ops_base;
    err_d    = err_base;
    done_d   = 1'b0;
    accept_d = 1'b0;
    depth_op = D_HOLD;
    if (bus.in_valid) begin
      unique case (state_q)
        S_IDLE: begin
          if (is_dig) begin
            state_d  = S_NUM;
            digits_d = DGW'(1);
            ops_d    = ops_inc;
          end else if (is_lp) begin
            state_d  = S_OPR;
            depth_op = D_INC;
          end else if (!is_term) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
        S_NUM: begin
          if (is_dig) begin
            if (digits_q == DGW'(MAX_DIGITS)) begin
              state_d = S_ERR;
              err_d   = 1'b1;
            end else begin
              digits_d = digits_q + 1'b1;
            end
          end else if (is_op) begin
            state_d = S_OPR;
          end else if (is_rp && !depth_zero) begin
            state_d  = S_CLS;
            depth_op = D_DEC;
          end else if (is_term) begin
            state_d  = S_IDLE;
            digits_d = '0;
            depth_op = D_CLR;
            done_d   = 1'b1;
            accept_d = depth_zero;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
        S_OPR: begin
          if (is_dig) begin
            state_d  = S_NUM;
            digits_d = DGW'(1);
            ops_d    = ops_inc;
          end else if (is_lp && !depth_full) begin
            depth_op = D_INC;
          end else if (is_term) begin
            // Dangling operator or open paren: flagged as an error and finished at once.
            state_d  = S_IDLE;
            digits_d = '0;
            depth_op = D_CLR;
            err_d    = 1'b1;
            done_d   = 1'b1;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
        S_CLS: begin
          if (is_op) begin
            state_d = S_OPR;
          end else if (is_rp && !depth_zero) begin
            depth_op = D_DEC;
          end else if (is_term) begin
            state_d  = S_IDLE;
            digits_d = '0;
            depth_op = D_CLR;
            done_d   = 1'b1;
            accept_d = depth_zero;
          end else begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
        S_ERR: begin
          if (is_term) begin
            state_d  = S_IDLE;
            digits_d = '0;
            depth_op = D_CLR;
            done_d   = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

`ifdef PAREN_EN
  localparam int DW = $clog2(MAX_DEPTH + 1);

  logic [DW-1:0] depth_q, depth_d;

  always_comb begin
    unique case (depth_op)
      D_INC:   depth_d = depth_q + DW'(1);
      D_DEC:   depth_d = depth_q - DW'(1);
      D_CLR:   depth_d = '0;
      default: depth_d = depth_q;
    endcase
  end

  assign depth_zero   = (depth_q == '0);
  assign depth_full   = (depth_q == DW'(MAX_DEPTH));
  assign depth_d_zero = (depth_d == '0);

  always_ff @(posedge clk or posedge clr) begin
    if (clr) depth_q <= '0;
    else     depth_q <= depth_d;
  end
`else
  logic unused_depth_op;

  assign depth_zero      = 1'b1;
  assign depth_full      = 1'b0;
  assign depth_d_zero    = 1'b1;
  assign unused_depth_op = ^depth_op;
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q    <= S_IDLE;
      digits_q   <= '0;
      operands_q <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      accept_q   <= 1'b0;
      out_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      digits_q   <= digits_d;
      operands_q <= ops_d;
      err_q      <= err_d;
      done_q     <= done_d;
      accept_q   <= accept_d;
      out_q      <= ((state_d == S_NUM) || (state_d == S_CLS)) && depth_d_zero;
    end
  end

  assign bus.out       = out_q;
  assign bus.err       = err_q;
  assign bus.done      = done_q;
  assign bus.accept    = accept_q;
  assign bus.operands  = operands_q;
  assign bus.dbg_state = state_q;

endmodule
